instr_encoder_loader: RTL and testbench

//  Encodes RV32I instruction fields (opcode, rd, rs1, rs2, funct3, funct7, imm) into 32-bit words,
//  the inverse of instruction decode. Writes each word to sequential instruction-memory addresses.

---
 rtl/instr_encoder_loader.sv | 188 ++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// RV32I field-to-word encoder that writes each encoded instruction to consecutive
// instruction-memory words over a we/ack port; malformed bundles raise a sticky error.
module instr_encoder_loader #(
    parameter int unsigned MEM_ADDR_WIDTH = 10,
    parameter int unsigned BASE_ADDR      = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [6:0]                in_opcode,
    input  logic [4:0]                in_rd,
    input  logic [4:0]                in_rs1,
    input  logic [4:0]                in_rs2,
    input  logic [2:0]                in_funct3,
    input  logic [6:0]                in_funct7,
    input  logic [31:0]               in_imm,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]               mem_wdata,
    input  logic                      mem_ack,
    output logic [MEM_ADDR_WIDTH:0]   count,
    output logic                      err,
    output logic [1:0]                err_code
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FULL
    } state_t;

    typedef enum logic [6:0] {
        OP_R       = 7'b0110011,
        OP_I_LOGIC = 7'b0010011,
        OP_I_LOAD  = 7'b0000011,
        OP_S       = 7'b0100011,
        OP_B       = 7'b1100011,
        OP_J       = 7'b1101111
    } opcode_t;

    localparam logic [MEM_ADDR_WIDTH-1:0] BASE     = MEM_ADDR_WIDTH'(BASE_ADDR);
    localparam logic [MEM_ADDR_WIDTH:0]   CAPACITY = {1'b1, {MEM_ADDR_WIDTH{1'b0}}};

    state_t                    r_state;
    logic                      r_live;
    logic                      r_we;
    logic [MEM_ADDR_WIDTH-1:0] r_addr;
    logic [31:0]               r_wdata;
    logic [MEM_ADDR_WIDTH:0]   r_count;
    logic                      r_err;
    logic [1:0]                r_err_code;

    logic signed [31:0]        w_imm;
    logic [31:0]               w_word;
    logic                      w_bad_op;
    logic                      w_misalign;
    logic                      w_range;
    logic [1:0]                w_code;
    logic                      w_fault;
    logic                      w_ready;
    logic                      w_accept;
    logic [MEM_ADDR_WIDTH:0]   w_count_inc;

    assign w_imm = $signed(in_imm);

    always_comb begin
        w_word     = '0;
        w_bad_op   = 1'b0;
        w_misalign = 1'b0;
        w_range    = 1'b0;
        case (in_opcode)
            OP_R: begin
                w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            end
            OP_I_LOGIC, OP_I_LOAD: begin
                // Shift-immediates carry funct7 above a 5-bit shamt instead of imm[11:5]
                if (in_opcode == OP_I_LOGIC && (in_funct3 == 3'b001 || in_funct3 == 3'b101)) begin
                    w_range = (w_imm < 32'sd0) || (w_imm > 32'sd31);
                    w_word  = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                end else begin
                    w_range = (w_imm < -32'sd2048) || (w_imm > 32'sd2047);
                    w_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                end
            end
            OP_S: begin
                w_range = (w_imm < -32'sd2048) || (w_imm > 32'sd2047);
                w_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            end
            OP_B: begin
                w_misalign = in_imm[0];
                w_range    = (w_imm < -32'sd4096) || (w_imm > 32'sd4094);
                w_word     = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], in_opcode};
            end
            OP_J: begin
                w_misalign = in_imm[0];
                w_range    = (w_imm < -32'sd1048576) || (w_imm > 32'sd1048574);
                w_word     = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            end
            default: begin
                w_bad_op = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_code = 2'b00;
        if (w_misalign) begin
            w_code = 2'b11;
        end else if (w_range) begin
            w_code = 2'b10;
        end else if (w_bad_op) begin
            w_code = 2'b01;
        end
    end

    assign w_fault     = (w_code != 2'b00);
    assign w_ready     = r_live && (r_state == IDLE) && !start;
    assign w_accept    = in_valid && w_ready;
    assign w_count_inc = r_count + (MEM_ADDR_WIDTH + 1)'(1);

    // r_live keeps in_ready low while reset is held and for the first edge after release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_live     <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= BASE;
            r_wdata    <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_live <= 1'b1;
            if (start) begin
                r_state    <= IDLE;
                r_we       <= 1'b0;
                r_addr     <= BASE;
                r_count    <= '0;
                r_err      <= 1'b0;
                r_err_code <= 2'b00;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            if (w_fault) begin
                                r_err <= 1'b1;
                                if (!r_err) begin
                                    r_err_code <= w_code;
                                end
                            end else begin
                                r_wdata <= w_word;
                                r_we    <= 1'b1;
                                r_state <= WRITE;
                            end
                        end
                    end
                    WRITE: begin
                        if (mem_ack) begin
                            r_we    <= 1'b0;
                            r_addr  <= r_addr + MEM_ADDR_WIDTH'(1);
                            r_count <= w_count_inc;
                            r_state <= (w_count_inc == CAPACITY) ? FULL : IDLE;
                        end
                    end
                    FULL: begin
                        r_we <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_we    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign in_ready  = w_ready;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign count     = r_count;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: directed bundles push expected writes,
// a monitor pops and compares each acknowledged memory write.
module tb_instr_encoder_loader;

    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [6:0]    in_opcode = '0;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_rs1 = '0;
    logic [4:0]    in_rs2 = '0;
    logic [2:0]    in_funct3 = '0;
    logic [6:0]    in_funct7 = '0;
    logic [31:0]   in_imm = '0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ack = 1'b0;
    logic [AW:0]   count;
    logic          err;
    logic [1:0]    err_code;

    int tests = 0;
    int fails = 0;
    int ack_delay = 0;
    int ack_cnt = 0;
    logic [AW-1:0] exp_ptr = '0;
    logic [AW+31:0] sb[$];

    instr_encoder_loader #(.MEM_ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .count(count), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: acks after ack_delay cycles of mem_we being high
    always @(posedge clk) begin
        #1;
        if (mem_we && ack_cnt >= ack_delay) begin
            mem_ack = 1'b1;
        end else begin
            mem_ack = 1'b0;
            if (mem_we) ack_cnt++;
            else ack_cnt = 0;
        end
    end

    // Monitor: every accepted write must match the head of the scoreboard
    always @(negedge clk) begin
        logic [AW+31:0] e;
        if (reset && mem_we && mem_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {mem_addr, mem_wdata}, 32'hDEAD);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e[AW+31:32]));
                chk("wr_data", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input bit exp_wr, input logic [31:0] exp_word);
        int guard = 0;
        in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (exp_wr) begin
            sb.push_back({exp_ptr, exp_word});
            exp_ptr = exp_ptr + 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("we_latency", 32'(mem_we), 32'(exp_wr));
    endtask

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while ((sb.size() != 0 || mem_we) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_ptr = '0;
        @(negedge clk);
        chk("start_addr", 32'(mem_addr), 32'd0);
        chk("start_count", 32'(count), 32'd0);
        chk("start_err", {29'd0, err, err_code}, 32'd0);
        chk("start_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_err", {29'd0, err, err_code}, 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // add x3,x1,x2 ; addi x5,x0,-1
        send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0, 1'b1, 32'h002081B3);
        send(7'b0010011, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF00293);
        wait_idle();
        chk("count_2", 32'(count), 32'd2);

        // sw x2,8(x1) with ack held off three cycles
        ack_delay = 3;
        send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 1'b1, 32'h0020A423);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_ack", 32'(mem_ack), 32'd0);
            chk("hold_we", 32'(mem_we), 32'd1);
            chk("hold_addr", 32'(mem_addr), 32'd2);
            chk("hold_wdata", mem_wdata, 32'h0020A423);
            chk("hold_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        chk("ack_seen", 32'(mem_ack), 32'd1);
        @(negedge clk);
        chk("ready_after_ack", 32'(in_ready), 32'd1);
        chk("count_3", 32'(count), 32'd3);
        ack_delay = 0;
        @(posedge clk); #1;

        // beq x1,x2,-4 fills the 4-word memory
        send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'hFFFFFFFC, 1'b1, 32'hFE208EE3);
        wait_idle();
        chk("full_count", 32'(count), 32'd4);
        chk("full_wrap_addr", 32'(mem_addr), 32'd0);
        in_opcode = 7'b0110011; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("full_ready", 32'(in_ready), 32'd0);
            chk("full_we", 32'(mem_we), 32'd0);
        end
        @(posedge clk); #1; in_valid = 1'b0;
        do_start();

        // Error flag: first code kept, misalignment beats range
        send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3, 1'b0, 32'd0);
        chk("mis_err", {29'd0, err, err_code}, 32'h7);
        chk("mis_idle_ready", 32'(in_ready), 32'd1);
        send(7'b0010011, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4096, 1'b0, 32'd0);
        chk("sticky_code", {29'd0, err, err_code}, 32'h7);
        chk("err_count", 32'(count), 32'd0);
        do_start();
        send(7'b1111111, 5'd1, 5'd1, 5'd1, 3'b000, 7'd0, 32'd0, 1'b0, 32'd0);
        chk("badop_code", {29'd0, err, err_code}, 32'h5);
        do_start();
        send(7'b0010011, 5'd7, 5'd8, 5'd0, 3'b001, 7'd0, 32'd32, 1'b0, 32'd0);
        chk("shamt_range", {29'd0, err, err_code}, 32'h6);
        do_start();
        send(7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4096, 1'b0, 32'd0);
        chk("b_range", {29'd0, err, err_code}, 32'h6);
        do_start();
        send(7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4097, 1'b0, 32'd0);
        chk("mis_priority", {29'd0, err, err_code}, 32'h7);
        do_start();

        // slli, srai, lw, jal
        send(7'b0010011, 5'd7, 5'd8, 5'd0, 3'b001, 7'b0000000, 32'd5, 1'b1, 32'h00541393);
        send(7'b0010011, 5'd7, 5'd8, 5'd0, 3'b101, 7'b0100000, 32'd3, 1'b1, 32'h40345393);
        send(7'b0000011, 5'd4, 5'd2, 5'd0, 3'b010, 7'd0, 32'hFFFFFFFC, 1'b1, 32'hFFC12203);
        send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, 1'b1, 32'h001000EF);
        wait_idle();
        chk("full2_count", 32'(count), 32'd4);
        do_start();

        // jal x0,-2 ; beq x0,x0,4094
        send(7'b1101111, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFFFFFE, 1'b1, 32'hFFFFF06F);
        send(7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4094, 1'b1, 32'h7E000FE3);
        wait_idle();
        chk("no_err", {29'd0, err, err_code}, 32'd0);

        // Reset while a write is pending
        ack_delay = 1000;
        send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0, 1'b1, 32'h002081B3);
        #2; reset = 1'b0;
        #1;
        sb.delete();
        exp_ptr = '0;
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_wdata", mem_wdata, 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        ack_delay = 0;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b1; in_opcode = 7'b0110011;
        @(negedge clk);
        chk("start_blocks_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
        chk("start_no_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        chk("final_ready", 32'(in_ready), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
